life_grid_engine: RTL and testbench
===================================

# life_grid_engine

Parametrised Game-of-Life generation engine. It holds a ROWS×COLS cell grid, double-buffered as current and next. It evaluates LANES cells per clock against a runtime-programmable birth/survive rule, with dead or toroidal edges, and commits whole generations atomically. It sits between the pattern loader/host and the display readout, and replaces the fixed 256×256, 16-lane, B3/S23 engine.

## Interface
- ROWS, 64, grid height; power of two, ≥4
- COLS, 64, grid width; power of two, ≥4
- LANES, 16, cells evaluated per cycle; power of two, divides COLS
- WRAP, 0, 0 = cells outside grid are dead; 1 = toroidal wrap on both axes
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- wr_en  in  1  load-port write strobe; honoured only in IDLE
- wr_row  in  $clog2(ROWS)  write row
- wr_col  in  $clog2(COLS)  write column
- wr_val  in  1  cell value written (1 = alive)
- clear  in  1  zero entire current grid; honoured only in IDLE
- start  in  1  compute one generation; level-sampled in IDLE
- run  in  1  free-run; keep computing generations while high
- birth_mask  in  9  bit n set = dead cell with n live neighbours becomes alive
- survive_mask  in  9  bit n set = live cell with n live neighbours stays alive
- rd_row  in  $clog2(ROWS)  readout row
- rd_col  in  $clog2(COLS)  readout column
- rd_val  out  1  current-grid cell at (rd_row, rd_col), registered
- busy  out  1  high in SWEEP and COMMIT
- gen_done  out  1  one-cycle pulse per committed generation
- gen_count  out  32  committed generations since reset/clear

## Operation
- FSM states: IDLE, SWEEP, COMMIT.
- IDLE → SWEEP when (start | run) is high. Both masks are latched on this transition and held for the whole generation.
- SWEEP: a (row, chunk) pointer starts at (0,0). Each cycle it evaluates cells row, chunk*LANES .. chunk*LANES+LANES-1 from the current grid and writes the results into the next grid. Chunk increments; at the last chunk it resets to 0 and row increments. When row ROWS-1 / last chunk has been processed, the FSM moves to COMMIT.
- COMMIT: the current grid takes the next grid in one cycle, gen_count increments (wraps at 2^32), and gen_done pulses. Next state is SWEEP if run is high, otherwise IDLE. On a COMMIT→SWEEP transition the masks are relatched.
- Neighbour count: sum of 8 neighbours, 4-bit, range 0..8. Next cell = alive ? survive_mask[cnt] : birth_mask[cnt].
- Edges: with WRAP=0, any neighbour index <0 or ≥ limit reads 0. With WRAP=1, indices are taken mod ROWS/COLS. This applies to rows and columns independently and includes chunk boundaries at column 0 and COLS-1.
- Lane neighbours come from the current grid only; results never feed back within a generation.
- Load port writes the current grid.
  - wr_en and clear are ignored while busy.
  - clear has priority over wr_en in the same cycle. clear also zeroes gen_count.
  - wr_en together with start in IDLE: the write lands, and the generation sweeps the grid including that write.
- start or run asserted while busy has no effect beyond run deciding the COMMIT exit.
- Dropping run mid-sweep finishes the current generation, then returns to IDLE.

## Timing
- Reset values: rd_val=0, busy=0, gen_done=0, gen_count=0, FSM=IDLE, pointers 0. Both grids are cleared.
- Reset mid-SWEEP or mid-COMMIT aborts the generation. No commit occurs and gen_done does not pulse.
- N = ROWS*COLS/LANES.
- Timeline for a start sampled at edge k:
  - busy is high from edge k through edge k+N+1.
  - Chunks are processed at edges k+1..k+N.
  - The commit and the gen_done pulse occur at edge k+N+1, so latency is N+1 cycles.
  - busy drops at edge k+N+1 unless run is high.
- Free-run period: N+1 cycles per generation, with no IDLE bubble.
- rd_val: registered, 1-cycle latency. During COMMIT it shows the pre-commit value; the new value is visible for reads sampled after the commit edge.
- Load writes are visible on rd_val 2 cycles after wr_en: 1 cycle to write, 1 cycle to read.

## Test plan
- ROWS=COLS=8, LANES=4, WRAP=0. Load a horizontal blinker at (3,2),(3,3),(3,4) and start with B3/S23 (birth_mask=0x008, survive_mask=0x00C) → after 17 cycles gen_done pulses and live cells are exactly (2,3),(3,3),(4,3). After a second start the original pattern returns and gen_count=2.
- Load a block at (0,0),(0,1),(1,0),(1,1), B3/S23:
  - WRAP=0 → unchanged after 5 generations.
  - WRAP=1 with the block at corner cells (0,0),(0,7),(7,0),(7,7) → also unchanged, proving wrap.
- Glider with WRAP=1, run held for 32 generations on the 8×8 grid → pattern is identical to the initial one, shifted (+8,+8) ≡ (0,0). gen_done fires once per generation with a 17-cycle period.
- Custom rule B1/S (birth_mask=0x002, survive_mask=0) on a single cell at (4,4) → next generation has the 8 neighbours alive and (4,4) dead.
- Assert wr_en at (0,0) and clear during SWEEP → both are ignored; the grid matches the pure rule result.
- Assert rst at sweep cycle 5 → busy=0 and gen_done never pulses. rd_val reads 0 at every cell, and gen_count=0.

Source files
------------

// File: rtl/life_grid_engine.sv
// Double-buffered Game-of-Life engine: sweeps the current grid LANES cells per cycle
// into the next grid under a programmable birth/survive rule, then commits atomically.
module life_grid_engine #(
    parameter int ROWS  = 64,
    parameter int COLS  = 64,
    parameter int LANES = 16,
    parameter int WRAP  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic                    wr_val,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    run,
    input  logic [8:0]              birth_mask,
    input  logic [8:0]              survive_mask,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    input  logic [$clog2(COLS)-1:0] rd_col,
    output logic                    rd_val,
    output logic                    busy,
    output logic                    gen_done,
    output logic [31:0]             gen_count
);

    localparam int RW    = $clog2(ROWS);
    localparam int NCH   = COLS / LANES;
    localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CELLS = ROWS * COLS;

    typedef enum logic [1:0] {IDLE, SWEEP, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [CELLS-1:0]   curGrid_q, nxtGrid_q;
    logic [RW-1:0]      rowPtr_q;
    logic [KW-1:0]      chunkPtr_q;
    logic [8:0]         birthMask_q, survMask_q;
    logic [31:0]        genCount_q;
    logic               genDone_q, rdVal_q;
    logic [LANES-1:0]   laneRes;
    logic               lastChunk, lastRow;

    // Out-of-grid neighbours are either dead or folded back with a power-of-two mask.
    function automatic logic cellAt(input logic [CELLS-1:0] g, input int r, input int c);
        int rr, cc;
        rr = r;
        cc = c;
        if (WRAP != 0) begin
            rr = r & (ROWS - 1);
            cc = c & (COLS - 1);
        end else if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
            return 1'b0;
        end
        return g[rr*COLS + cc];
    endfunction

    function automatic logic nextCell(input logic [CELLS-1:0] g, input int r, input int c,
                                      input logic [8:0] bm, input logic [8:0] sm);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    cnt = cnt + {3'b000, cellAt(g, r + dr, c + dc)};
                end
            end
        end
        return cellAt(g, r, c) ? sm[cnt] : bm[cnt];
    endfunction

    always_comb begin
        laneRes = '0;
        for (int l = 0; l < LANES; l++) begin
            laneRes[l] = nextCell(curGrid_q, int'(rowPtr_q), int'(chunkPtr_q) * LANES + l,
                                  birthMask_q, survMask_q);
        end
    end

    assign lastChunk = (chunkPtr_q == KW'(NCH - 1));
    assign lastRow   = (rowPtr_q == RW'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start || run)         state_d = SWEEP;
            SWEEP:   if (lastRow && lastChunk) state_d = COMMIT;
            COMMIT:  state_d = run ? SWEEP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            curGrid_q   <= '0;
            nxtGrid_q   <= '0;
            rowPtr_q    <= '0;
            chunkPtr_q  <= '0;
            birthMask_q <= '0;
            survMask_q  <= '0;
            genCount_q  <= '0;
            genDone_q   <= 1'b0;
            rdVal_q     <= 1'b0;
        end else begin
            genDone_q <= 1'b0;
            rdVal_q   <= curGrid_q[{rd_row, rd_col}];
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        curGrid_q  <= '0;
                        genCount_q <= '0;
                    end else if (wr_en) begin
                        curGrid_q[{wr_row, wr_col}] <= wr_val;
                    end
                    if (start || run) begin
                        birthMask_q <= birth_mask;
                        survMask_q  <= survive_mask;
                        rowPtr_q    <= '0;
                        chunkPtr_q  <= '0;
                    end
                end
                SWEEP: begin
                    nxtGrid_q[int'(rowPtr_q)*COLS + int'(chunkPtr_q)*LANES +: LANES] <= laneRes;
                    if (lastChunk) begin
                        chunkPtr_q <= '0;
                        rowPtr_q   <= rowPtr_q + RW'(1);
                    end else begin
                        chunkPtr_q <= chunkPtr_q + KW'(1);
                    end
                end
                COMMIT: begin
                    curGrid_q  <= nxtGrid_q;
                    genCount_q <= genCount_q + 32'd1;
                    genDone_q  <= 1'b1;
                    rowPtr_q   <= '0;
                    chunkPtr_q <= '0;
                    if (run) begin
                        birthMask_q <= birth_mask;
                        survMask_q  <= survive_mask;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign gen_done  = genDone_q;
    assign gen_count = genCount_q;
    assign rd_val    = rdVal_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Drives an 8x8, 4-lane engine in both edge modes side by side and compares every
// generation against a whole-grid behavioural Life model.
module tb_life_grid_engine;

    localparam int R = 8;
    localparam int C = 8;
    localparam int N = R * C / 4;

    logic        clk = 1'b0;
    logic        rst, wrEn, wrVal, clear, start, run;
    logic [2:0]  wrRow, wrCol, rdRow, rdCol;
    logic [8:0]  birthMask, survMask;
    logic [1:0]  rdVal, busy, genDone;
    logic [31:0] genCount0, genCount1;

    int checks = 0;
    int errors = 0;
    int expGen = 0;

    always #5 clk = ~clk;

    life_grid_engine #(.ROWS(R), .COLS(C), .LANES(4), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_row(wrRow), .wr_col(wrCol), .wr_val(wrVal),
        .clear(clear), .start(start), .run(run), .birth_mask(birthMask),
        .survive_mask(survMask), .rd_row(rdRow), .rd_col(rdCol), .rd_val(rdVal[0]),
        .busy(busy[0]), .gen_done(genDone[0]), .gen_count(genCount0)
    );

    life_grid_engine #(.ROWS(R), .COLS(C), .LANES(4), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_row(wrRow), .wr_col(wrCol), .wr_val(wrVal),
        .clear(clear), .start(start), .run(run), .birth_mask(birthMask),
        .survive_mask(survMask), .rd_row(rdRow), .rd_col(rdCol), .rd_val(rdVal[1]),
        .busy(busy[1]), .gen_done(genDone[1]), .gen_count(genCount1)
    );

    typedef struct {
        string       name;
        logic [63:0] pat;
        logic [8:0]  bm;
        logic [8:0]  sm;
        logic [63:0] exp0;
        logic [63:0] exp1;
    } vec_t;

    vec_t vecs[6];

    // Whole-grid Life rule: each cell counts its in-range (or wrapped) live neighbours.
    function automatic logic [63:0] modelGen(input logic [63:0] g, input bit wrap,
                                             input logic [8:0] bm, input logic [8:0] sm);
        logic [63:0] res;
        res = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int nr, nc;
                        nr = r + dr;
                        nc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            nr = (nr + R) % R;
                            nc = (nc + C) % C;
                        end else if (nr < 0 || nr >= R || nc < 0 || nc >= C) begin
                            continue;
                        end
                        n += int'(g[nr*C + nc]);
                    end
                end
                res[r*C + c] = g[r*C + c] ? sm[n] : bm[n];
            end
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Clears the grid (which also zeroes gen_count) then writes every live cell.
    task automatic applyStimulus(input logic [63:0] pat);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expGen = 0;
        for (int i = 0; i < 64; i++) begin
            if (pat[i]) begin
                wrEn  = 1'b1;
                wrRow = 3'(i / C);
                wrCol = 3'(i % C);
                wrVal = 1'b1;
                tick();
            end
        end
        wrEn = 1'b0;
    endtask

    task automatic readGrids(output logic [63:0] g0, output logic [63:0] g1);
        g0 = '0;
        g1 = '0;
        for (int i = 0; i < 64; i++) begin
            rdRow = 3'(i / C);
            rdCol = 3'(i % C);
            tick();
            g0[i] = rdVal[0];
            g1[i] = rdVal[1];
        end
    endtask

    task automatic waitDone(input string name, output int cyc);
        cyc = 0;
        while (genDone[0] !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        checkOutput({name, " done agree"}, 64'(genDone[1]), 64'(genDone[0]));
    endtask

    task automatic runGen(input string name);
        int cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        wrEn  = 1'b0;
        checkOutput({name, " busy"}, 64'(busy), 64'h3);
        waitDone(name, cyc);
        checkOutput({name, " latency"}, 64'(cyc), 64'(N + 1));
        checkOutput({name, " busy after"}, 64'(busy), 64'h0);
        expGen++;
        checkOutput({name, " count0"}, 64'(genCount0), 64'(expGen));
        checkOutput({name, " count1"}, 64'(genCount1), 64'(expGen));
        tick();
        checkOutput({name, " pulse width"}, 64'(genDone), 64'h0);
    endtask

    logic [63:0] g0, g1, m0, m1, pat;
    localparam logic [63:0] BLINKER = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
    localparam logic [63:0] CORNERS = 64'h8100_0000_0000_0081;
    localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

    initial begin
        vecs[0] = '{"blinker",  BLINKER, 9'h008, 9'h00C,
                    64'h0000_0008_0808_0000, 64'h0000_0008_0808_0000};
        vecs[1] = '{"block",    BLOCK,   9'h008, 9'h00C, BLOCK, BLOCK};
        vecs[2] = '{"corners",  CORNERS, 9'h008, 9'h00C, 64'h0, CORNERS};
        vecs[3] = '{"b1 seed",  64'h0000_0010_0000_0000, 9'h002, 9'h000,
                    64'h0000_3828_3800_0000, 64'h0000_3828_3800_0000};
        vecs[4] = '{"b0 empty", 64'h0, 9'h001, 9'h000, '1, '1};
        vecs[5] = '{"s8 full",  '1, 9'h000, 9'h100, 64'h007E_7E7E_7E7E_7E00, '1};

        rst = 1'b1; wrEn = 0; wrVal = 0; clear = 0; start = 0; run = 0;
        wrRow = 0; wrCol = 0; rdRow = 0; rdCol = 0; birthMask = 0; survMask = 0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset busy", 64'(busy), 64'h0);
        checkOutput("reset done", 64'(genDone), 64'h0);
        checkOutput("reset count", 64'(genCount0 | genCount1), 64'h0);
        readGrids(g0, g1);
        checkOutput("reset grid0", g0, 64'h0);
        checkOutput("reset grid1", g1, 64'h0);

        foreach (vecs[v]) begin
            birthMask = vecs[v].bm;
            survMask  = vecs[v].sm;
            applyStimulus(vecs[v].pat);
            runGen(vecs[v].name);
            readGrids(g0, g1);
            checkOutput({vecs[v].name, " grid0"}, g0, vecs[v].exp0);
            checkOutput({vecs[v].name, " grid1"}, g1, vecs[v].exp1);
        end

        birthMask = 9'h008;
        survMask  = 9'h00C;
        applyStimulus(BLINKER);
        runGen("blinker g1");
        runGen("blinker g2");
        readGrids(g0, g1);
        checkOutput("blinker back0", g0, BLINKER);
        checkOutput("blinker back1", g1, BLINKER);
        checkOutput("blinker count", 64'(genCount0), 64'd2);

        applyStimulus(BLOCK);
        for (int i = 0; i < 5; i++) runGen("block5");
        readGrids(g0, g1);
        checkOutput("block5 grid0", g0, BLOCK);
        checkOutput("block5 grid1", g1, BLOCK);

        applyStimulus(CORNERS);
        for (int i = 0; i < 5; i++) runGen("corners5");
        readGrids(g0, g1);
        checkOutput("corners5 grid1", g1, CORNERS);
        checkOutput("corners5 grid0", g0, 64'h0);

        // Free-run the glider 32 generations; run drops mid-sweep of the last one.
        begin
            int cyc, last, gens;
            applyStimulus(GLIDER);
            m0 = GLIDER;
            for (int i = 0; i < 32; i++) m0 = modelGen(m0, 1'b0, 9'h008, 9'h00C);
            run = 1'b1;
            tick();
            cyc = 0; last = 0; gens = 0;
            while (gens < 32 && cyc < 40 * (N + 1)) begin
                tick();
                cyc++;
                if (genDone[0] === 1'b1) begin
                    gens++;
                    checkOutput("glider period", 64'(cyc - last), 64'(N + 1));
                    last = cyc;
                    if (gens == 31) run = 1'b0;
                end
            end
            expGen = 32;
            checkOutput("glider gens", 64'(gens), 64'd32);
            checkOutput("glider count", 64'(genCount1), 64'd32);
            checkOutput("glider idle", 64'(busy), 64'h0);
            readGrids(g0, g1);
            checkOutput("glider grid1", g1, GLIDER);
            checkOutput("glider grid0", g0, m0);
        end

        for (int it = 0; it < 6; it++) begin
            pat       = {$urandom, $urandom};
            birthMask = 9'($urandom);
            survMask  = 9'($urandom);
            applyStimulus(pat);
            m0 = modelGen(pat, 1'b0, birthMask, survMask);
            m1 = modelGen(pat, 1'b1, birthMask, survMask);
            runGen("random");
            readGrids(g0, g1);
            checkOutput("random grid0", g0, m0);
            checkOutput("random grid1", g1, m1);
        end

        // A write issued with start lands before the sweep reads the grid.
        pat = {$urandom, $urandom} & ~64'(1 << 45);
        birthMask = 9'h008;
        survMask  = 9'h00C;
        applyStimulus(pat);
        wrEn = 1'b1; wrRow = 3'd5; wrCol = 3'd5; wrVal = 1'b1;
        pat[45] = 1'b1;
        runGen("write+start");
        readGrids(g0, g1);
        checkOutput("write+start grid0", g0, modelGen(pat, 1'b0, 9'h008, 9'h00C));
        checkOutput("write+start grid1", g1, modelGen(pat, 1'b1, 9'h008, 9'h00C));

        // Load port, clear and mask changes during the sweep must not disturb it.
        begin
            int cyc;
            pat = {$urandom, $urandom};
            applyStimulus(pat);
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 3; i++) tick();
            clear = 1'b1; wrEn = 1'b1; wrRow = 3'd0; wrCol = 3'd0; wrVal = ~pat[0];
            birthMask = 9'h1FF; survMask = 9'h000;
            tick();
            clear = 1'b0; wrEn = 1'b0;
            waitDone("sweep ignore", cyc);
            expGen++;
            checkOutput("sweep ignore count", 64'(genCount0), 64'(expGen));
            readGrids(g0, g1);
            checkOutput("sweep ignore grid0", g0, modelGen(pat, 1'b0, 9'h008, 9'h00C));
            checkOutput("sweep ignore grid1", g1, modelGen(pat, 1'b1, 9'h008, 9'h00C));
            birthMask = 9'h008; survMask = 9'h00C;
        end

        // Reset partway through a sweep aborts it with no commit.
        begin
            logic seen;
            applyStimulus(BLINKER);
            start = 1'b1;
            tick();
            start = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                seen |= |genDone;
            end
            rst = 1'b1;
            tick();
            seen |= |genDone;
            rst = 1'b0;
            checkOutput("abort busy", 64'(busy), 64'h0);
            for (int i = 0; i < 2 * N; i++) begin
                tick();
                seen |= |genDone;
            end
            checkOutput("abort no done", 64'(seen), 64'h0);
            checkOutput("abort count0", 64'(genCount0), 64'h0);
            checkOutput("abort count1", 64'(genCount1), 64'h0);
            readGrids(g0, g1);
            checkOutput("abort grid0", g0, 64'h0);
            checkOutput("abort grid1", g1, 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
